// File: rtl/pop_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pop_scheduler_pkg
// Description : Shared scheduler definitions: FSM state encoding for the
//               IDLE/SERVE arbiters and a cyclic find-first-set helper used
//               by the FIFO, DWRR and pop_scheduler blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pop_scheduler_pkg;

    // Upper bound on requester count supported by cyc_ffs().
    localparam int c_MAX_REQS  = 32;
    localparam int c_PICK_IDXW = 5;

    // Scheduler FSM encoding.
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SERVE = 1'b1;

    typedef struct packed {
        logic                   found;
        logic [c_PICK_IDXW-1:0] idx;
    } pick_t;

    // Returns the first set bit of mask[num-1:0], scanning upward from
    // 'start' and wrapping past num-1 back to 0. found=0 when mask is empty.
    function automatic pick_t cyc_ffs(input logic [c_MAX_REQS-1:0] mask,
                                      input int                    num,
                                      input int                    start);
        pick_t r;
        int    pos;
        r   = '0;
        pos = 0;
        for (int k = 0; k < c_MAX_REQS; k++) begin
            if (k < num && !r.found) begin
                pos = (start + k) % num;
                if (mask[pos[c_PICK_IDXW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = pos[c_PICK_IDXW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pop_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational cyclic priority encoder. Finds the first set
//               bit of 'mask' starting at ptr+1 and wrapping at NUM_REQS-1.
// Ports       : mask  - request vector (bit i set = requester i wants service)
//               ptr   - index served last; the search begins just after it
//               index - selected requester (valid when found=1)
//               found - at least one mask bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import pop_scheduler_pkg::*;
#(
    parameter int NUM_REQS = 4,                 // must be 2..c_MAX_REQS
    parameter int IDXW     = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] mask,
    input  logic [IDXW-1:0]     ptr,
    output logic [IDXW-1:0]     index,
    output logic                found
);

    logic [c_MAX_REQS-1:0] w_mask_ext;
    int                    w_start;
    pick_t                 w_pick;
    logic                  w_unused_idx;

    always_comb begin
        w_mask_ext                 = '0;
        w_mask_ext[NUM_REQS-1:0]   = mask;
        w_start                    = (int'(ptr) + 1) % NUM_REQS;
        w_pick                     = cyc_ffs(w_mask_ext, NUM_REQS, w_start);
    end

    assign index        = w_pick.idx[IDXW-1:0];
    assign found        = w_pick.found;
    // High index bits are structurally zero for small NUM_REQS.
    assign w_unused_idx = ^w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/pop_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pop_scheduler
// Description : Round-robin burst scheduler that pops requester FIFOs
//               directly. Each turn costs one IDLE arbitration cycle followed
//               by up to burst_lim pops (a limit of 0 counts as 1). A turn is
//               forfeited as soon as the served FIFO runs dry; no deficit is
//               carried over.
// Ports       : clk            - clock, rising edge
//               rst            - asynchronous active-high reset
//               empty          - per-FIFO empty flags (low = requesting)
//               flat_burst_lim - packed per-requester pop limits, QWID each
//               out_rdy        - downstream accepts one packet this cycle
//               blk            - global stall; freezes all state
//               gnt            - one-hot pop strobe to the FIFOs
//               sel            - index of the requester being served
//               out_vld        - any pop this cycle
//               busy           - scheduler is in SERVE
// Revision    : 1.0 - initial release
// ============================================================================
module pop_scheduler
    import pop_scheduler_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int IDXW     = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQS-1:0]      empty,
    input  logic [NUM_REQS*QWID-1:0] flat_burst_lim,
    input  logic                     out_rdy,
    input  logic                     blk,
    output logic [NUM_REQS-1:0]      gnt,
    output logic [IDXW-1:0]          sel,
    output logic                     out_vld,
    output logic                     busy
);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [IDXW-1:0]     r_ptr;
    logic [IDXW-1:0]     r_sel;
    logic [QWID-1:0]     r_burst_cnt;

    logic [NUM_REQS-1:0] w_req;
    logic [IDXW-1:0]     w_pick_idx;
    logic                w_pick_found;
    logic [QWID-1:0]     w_pick_lim_raw;
    logic [QWID-1:0]     w_pick_lim;
    logic                w_sel_empty;
    logic                w_pop;
    logic                w_load;
    logic                w_turn_end;

    assign w_req = ~empty;

    rr_pick #(
        .NUM_REQS (NUM_REQS),
        .IDXW     (IDXW)
    ) u_rr_pick (
        .mask  (w_req),
        .ptr   (r_ptr),
        .index (w_pick_idx),
        .found (w_pick_found)
    );

    // Burst limit of the candidate; zero is promoted to one so a turn always
    // grants at least one pop.
    always_comb begin
        w_pick_lim_raw = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_pick_idx == IDXW'(i)) begin
                w_pick_lim_raw = flat_burst_lim[i*QWID +: QWID];
            end
        end
        w_pick_lim = (w_pick_lim_raw == '0) ? QWID'(1) : w_pick_lim_raw;
    end

    assign w_sel_empty = empty[r_sel];

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_turn_end  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_found && !blk) begin
                    w_state_nxt = c_ST_SERVE;
                    w_load      = 1'b1;
                end
            end
            c_ST_SERVE: begin
                // blk freezes everything, even a FIFO that has just run dry.
                if (!blk) begin
                    if (w_sel_empty || (w_pop && r_burst_cnt == QWID'(1))) begin
                        w_state_nxt = c_ST_IDLE;
                        w_turn_end  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy  = (r_state == c_ST_SERVE);
        w_pop = busy && !w_sel_empty && out_rdy && !blk;
    end

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_gnt
        assign gnt[gi] = w_pop && (r_sel == IDXW'(gi));
    end

    assign out_vld = |gnt;
    assign sel     = r_sel;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
        end else if (w_load) begin
            r_sel <= w_pick_idx;
        end
    end

    // Reset value NUM_REQS-1 makes the first search start at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IDXW'(NUM_REQS - 1);
        end else if (w_turn_end) begin
            r_ptr <= r_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else if (w_load) begin
            r_burst_cnt <= w_pick_lim;
        end else if (w_pop) begin
            r_burst_cnt <= r_burst_cnt - QWID'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pop_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pop_scheduler
// Description : Self-checking bench for pop_scheduler. FIFO occupancy is
//               modelled per requester; stimulus pushes the expected grant
//               vector and the cycle it must appear on into a scoreboard,
//               and a negedge monitor pops and compares on every out_vld.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pop_scheduler;

    localparam int NUM_REQS = 4;
    localparam int QWID     = 8;
    localparam int IDXW     = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQS-1:0]      empty;
    logic [NUM_REQS*QWID-1:0] flat_burst_lim;
    logic                     out_rdy;
    logic                     blk;
    logic [NUM_REQS-1:0]      gnt;
    logic [IDXW-1:0]          sel;
    logic                     out_vld;
    logic                     busy;

    logic [NUM_REQS-1:0] empty_ovr;
    logic                load_en;
    int                  load_cnt [NUM_REQS];
    int                  fill     [NUM_REQS];
    int                  cyc;
    int                  total;
    int                  bad;
    int                  base;

    typedef struct packed {
        logic [NUM_REQS-1:0] g;
        logic [31:0]         at;
    } exp_t;

    exp_t sb[$];

    pop_scheduler #(
        .NUM_REQS (NUM_REQS),
        .QWID     (QWID),
        .IDXW     (IDXW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .empty          (empty),
        .flat_burst_lim (flat_burst_lim),
        .out_rdy        (out_rdy),
        .blk            (blk),
        .gnt            (gnt),
        .sel            (sel),
        .out_vld        (out_vld),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // FIFO occupancy model: gnt pops one entry; load_en overwrites.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (load_en) begin
                fill[i] <= load_cnt[i];
            end else if (gnt[i]) begin
                fill[i] <= fill[i] - 1;
            end
        end
    end

    always_comb begin
        empty = empty_ovr;
        for (int i = 0; i < NUM_REQS; i++) begin
            empty[i] = empty[i] | (fill[i] == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard compare on every grant.
    always @(negedge clk) begin
        exp_t e;
        check("gnt_onehot0", 32'((gnt & (gnt - 1'b1)) == '0), 32'd1);
        check("gnt_to_empty", 32'(gnt & empty), 32'd0);
        check("vld_is_or_gnt", 32'(out_vld), 32'(|gnt));
        if (!out_rdy || blk || rst) begin
            check("gnt_gated", 32'(gnt), 32'd0);
        end
        if (out_vld) begin
            if (sb.size() == 0) begin
                check("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                e = sb.pop_front();
                check("gnt_val", 32'(gnt), 32'(e.g));
                check("gnt_cycle", 32'(cyc), e.at);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic expect_gnt(input int port, input int at);
        exp_t e;
        e.g  = NUM_REQS'(1) << port;
        e.at = 32'(at);
        sb.push_back(e);
    endtask

    task automatic set_lims(input int l0, input int l1, input int l2, input int l3);
        flat_burst_lim = {QWID'(l3), QWID'(l2), QWID'(l1), QWID'(l0)};
    endtask

    // Holds reset across two edges while loading FIFO contents; base is the
    // cycle count at release, so the first possible grant is at base+1.
    task automatic reset_and_load(input int c0, input int c1, input int c2, input int c3);
        rst         = 1'b1;
        load_cnt[0] = c0;
        load_cnt[1] = c1;
        load_cnt[2] = c2;
        load_cnt[3] = c3;
        load_en     = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        load_en = 1'b0;
        tick();
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic drain(input string name, input int target);
        run_until(target);
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l6;
        int b2;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        out_rdy   = 1'b1;
        blk       = 1'b0;
        empty_ovr = '0;
        load_en   = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) load_cnt[i] = 0;
        set_lims(2, 2, 2, 2);

        // Four full FIFOs, limit 2: two pops per port then one idle cycle.
        reset_and_load(4, 4, 4, 4);
        for (int t = 0; t < 8; t++) begin
            expect_gnt(t % 4, base + 1 + 3*t);
            expect_gnt(t % 4, base + 2 + 3*t);
        end
        drain("sc1_leftover", base + 28);
        check("sc1_idle_at_end", 32'(busy), 32'd0);

        // Lone FIFO 2 with 3 entries and limit 5: turn ends when it drains.
        set_lims(5, 5, 5, 5);
        reset_and_load(0, 0, 3, 0);
        for (int k = 1; k <= 3; k++) expect_gnt(2, base + k);
        run_until(base + 6);
        check("sc2_idle", 32'(busy), 32'd0);
        check("sc2_sel", 32'(sel), 32'd2);
        drain("sc2_leftover", base + 8);

        // Limit 3, out_rdy low for 3 cycles after the first pop; lone
        // requester is reselected for its next turn.
        set_lims(3, 3, 3, 3);
        reset_and_load(5, 0, 0, 0);
        expect_gnt(0, base + 1);
        expect_gnt(0, base + 5);
        expect_gnt(0, base + 6);
        expect_gnt(0, base + 8);
        expect_gnt(0, base + 9);
        run_until(base + 2);
        out_rdy = 1'b0;
        run_until(base + 4);
        check("sc3_stall_busy", 32'(busy), 32'd1);
        check("sc3_stall_sel", 32'(sel), 32'd0);
        run_until(base + 5);
        out_rdy = 1'b1;
        drain("sc3_leftover", base + 14);

        // blk held 4 cycles while FIFO 1 goes empty; on release the turn ends
        // with ptr=1, so the next search starts at port 2.
        set_lims(4, 4, 4, 4);
        reset_and_load(0, 5, 0, 0);
        expect_gnt(1, base + 1);
        run_until(base + 2);
        blk       = 1'b1;
        empty_ovr = 4'b0010;
        run_until(base + 3);
        check("sc4_blk_busy", 32'(busy), 32'd1);
        check("sc4_blk_sel", 32'(sel), 32'd1);
        run_until(base + 6);
        blk = 1'b0;
        check("sc4_held_busy", 32'(busy), 32'd1);
        run_until(base + 7);
        check("sc4_released_idle", 32'(busy), 32'd0);
        load_cnt[0] = 1;
        load_cnt[1] = 0;
        load_cnt[2] = 1;
        load_cnt[3] = 0;
        load_en     = 1'b1;
        tick();
        load_en   = 1'b0;
        empty_ovr = '0;
        expect_gnt(2, base + 9);
        expect_gnt(0, base + 12);
        drain("sc4_leftover", base + 16);

        // Port 1 limit 0 behaves as 1.
        set_lims(2, 0, 2, 2);
        reset_and_load(3, 3, 0, 0);
        expect_gnt(0, base + 1);
        expect_gnt(0, base + 2);
        expect_gnt(1, base + 4);
        expect_gnt(0, base + 6);
        expect_gnt(1, base + 9);
        expect_gnt(1, base + 11);
        drain("sc5_leftover", base + 15);

        // Reset during the second pop of a 4-burst on port 2 (ptr=1 left
        // from the previous run); the restart goes to port 1.
        set_lims(4, 4, 4, 4);
        load_cnt[0] = 0;
        load_cnt[1] = 8;
        load_cnt[2] = 8;
        load_cnt[3] = 0;
        load_en     = 1'b1;
        tick();
        load_en = 1'b0;
        l6      = cyc;
        expect_gnt(2, l6 + 1);
        run_until(l6 + 2);
        rst = 1'b1;
        #1;
        check("sc6_async_gnt", 32'(gnt), 32'd0);
        check("sc6_async_busy", 32'(busy), 32'd0);
        check("sc6_async_sel", 32'(sel), 32'd0);
        tick();
        rst = 1'b0;
        b2  = cyc;
        for (int k = 1; k <= 4; k++) expect_gnt(1, b2 + k);
        run_until(b2 + 5);
        rst = 1'b1;
        for (int i = 0; i < NUM_REQS; i++) load_cnt[i] = 0;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        check("sc6_leftover", 32'(sb.size()), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
